// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshake, overflow and illegal-op flags.
// Define ALU_MUL_EN to add the shift-add multiplier on opcode 10000 (WIDTH+1 cycle latency).
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic [4:0]              ALUOp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        C,
  output logic                    Zero,
  output logic                    Ovf,
  output logic                    Ill
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LUI   = 5'b00001;
  localparam logic [4:0] OP_AUIPC = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_SLT   = 5'b00101;
  localparam logic [4:0] OP_SLTU  = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00111;
  localparam logic [4:0] OP_SLL   = 5'b01000;
  localparam logic [4:0] OP_SRL   = 5'b01001;
  localparam logic [4:0] OP_SRA   = 5'b01011;
  localparam logic [4:0] OP_OR    = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;

  logic [WIDTH-1:0] r_c_p1;
  logic             r_zero_p1;
  logic             r_ovf_p1;
  logic             r_ill_p1;
  logic             r_vld_p1;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;
  logic             w_accept;
  logic             w_load;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;

  assign w_shamt  = B[SHW-1:0];
  assign w_accept = in_valid && in_ready;

  // nop and unrecognised opcodes default to the held result
  always_comb begin
    w_sum  = A + B;
    w_diff = A - B;
    w_res  = r_c_p1;
    w_ovf  = 1'b0;
    w_ill  = 1'b0;
    case (ALUOp)
      OP_NOP: ;
      OP_LUI, OP_AUIPC: w_res = B;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, ($unsigned(A) < $unsigned(B))};
      OP_XOR:  w_res = A ^ B;
      OP_SLL:  w_res = A << w_shamt;
      OP_SRL:  w_res = $unsigned(A) >> w_shamt;
      OP_SRA:  w_res = WIDTH'(A >>> w_shamt);
      OP_OR:   w_res = A | B;
      OP_AND:  w_res = A & B;
`ifdef ALU_MUL_EN
      5'b10000: w_res = r_c_p1;
`endif
      default: w_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [4:0]   OP_MUL   = 5'b10000;
  localparam logic [0:0]   S_IDLE   = 1'b0;
  localparam logic [0:0]   S_MUL    = 1'b1;
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  logic [0:0]       r_state;
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             w_is_mul;

  assign w_is_mul   = (ALUOp == OP_MUL);
  assign in_ready   = (r_state == S_IDLE) && (!r_vld_p1 || out_ready);
  assign w_load     = w_accept && !w_is_mul;
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);
  assign w_mul_res  = r_acc;

  // WIDTH add/shift steps, then one cycle to hand the product to the result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_is_mul) begin
        r_state  <= S_MUL;
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mcand  <= A;
        r_mplier <= B;
      end
    end else if (r_cnt == CNT_LAST) begin
      r_state <= S_IDLE;
    end else begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign in_ready   = !r_vld_p1 || out_ready;
  assign w_load     = w_accept;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
`endif

  // p1: result registers, held until the consumer takes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_p1    <= '0;
      r_zero_p1 <= 1'b1;
      r_ovf_p1  <= 1'b0;
      r_ill_p1  <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else if (w_mul_done) begin
      r_c_p1    <= w_mul_res;
      r_zero_p1 <= (w_mul_res == '0);
      r_ovf_p1  <= 1'b0;
      r_ill_p1  <= 1'b0;
      r_vld_p1  <= 1'b1;
    end else if (w_load) begin
      r_c_p1    <= w_res;
      r_zero_p1 <= (w_res == '0);
      r_ovf_p1  <= w_ovf;
      r_ill_p1  <= w_ill;
      r_vld_p1  <= 1'b1;
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign C         = r_c_p1;
  assign Zero      = r_zero_p1;
  assign Ovf       = r_ovf_p1;
  assign Ill       = r_ill_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed cases plus randomized traffic against a behavioural model.
module tb_alu_pipe;
  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [4:0]    ALUOp;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  C;
  logic          Zero;
  logic          Ovf;
  logic          Ill;

  int n_err;
  int n_chk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .Zero(Zero), .Ovf(Ovf), .Ill(Ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result as {ill, ovf, c}, computed with wide signed arithmetic
  function automatic logic [33:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] prev);
    longint sa, sb, r, ua, pw;
    logic [31:0] c;
    logic ovf, ill;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    pw  = longint'(1) << b[4:0];
    c   = prev;
    ovf = 1'b0;
    ill = 1'b0;
    r   = 0;
    case (op)
      5'b00000: ;
      5'b00001, 5'b00010: c = b;
      5'b00011: begin r = sa + sb; c = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      5'b00100: begin r = sa - sb; c = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      5'b00101: c = (sa < sb) ? 32'd1 : 32'd0;
      5'b00110: c = (ua < longint'({32'b0, b})) ? 32'd1 : 32'd0;
      5'b00111: c = a ^ b;
      5'b01000: begin r = ua * pw; c = r[31:0]; end
      5'b01001: begin r = ua / pw; c = r[31:0]; end
      5'b01011: begin r = sa >>> b[4:0]; c = r[31:0]; end
      5'b01100: c = a | b;
      5'b01101: c = a & b;
      default:  ill = 1'b1;
    endcase
    return {ill, ovf, c};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  // Behavioural model state
  logic        m_vld;
  logic        m_ovf;
  logic        m_ill;
  logic        m_acc_last;
  logic [31:0] m_c;
  logic [31:0] m_mul;
  int          m_rem;
  logic        m_in_ready;
  logic        m_accept;
  logic        m_is_mul;
  logic [33:0] m_res;

`ifdef ALU_MUL_EN
  assign m_is_mul = (ALUOp == 5'b10000);
`else
  assign m_is_mul = 1'b0;
`endif
  assign m_in_ready = (m_rem == 0) && (!m_vld || out_ready);
  assign m_accept   = in_valid && m_in_ready;
  assign m_res      = ref_alu(ALUOp, A, B, m_c);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld <= 1'b0; m_ovf <= 1'b0; m_ill <= 1'b0; m_c <= '0;
      m_mul <= '0; m_rem <= 0; m_acc_last <= 1'b0;
    end else begin
      m_acc_last <= m_accept;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_c <= m_mul; m_ovf <= 1'b0; m_ill <= 1'b0; m_vld <= 1'b1;
        end
      end else if (m_accept && m_is_mul) begin
        m_rem <= W + 1;
        m_mul <= ref_mul(A, B);
        m_vld <= 1'b0;
      end else if (m_accept) begin
        {m_ill, m_ovf, m_c} <= m_res;
        m_vld <= 1'b1;
      end else if (out_ready) begin
        m_vld <= 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", out_valid, m_vld);
      chk("in_ready", in_ready, m_in_ready);
      if (m_vld) begin
        chk("C", C, m_c);
        chk("Zero", Zero, (m_c == 0));
        chk("Ovf", Ovf, m_ovf);
        chk("Ill", Ill, m_ill);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); #1;
    in_valid = 1'b1; ALUOp = op; A = a; B = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] c, input logic z,
                         input logic o, input logic i);
    chk({tag, "_C"}, C, c);
    chk({tag, "_Zero"}, Zero, z);
    chk({tag, "_Ovf"}, Ovf, o);
    chk({tag, "_Ill"}, Ill, i);
    chk({tag, "_out_valid"}, out_valid, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_C"}, C, 32'h0);
    chk({tag, "_Zero"}, Zero, 1'b1);
    chk({tag, "_Ovf"}, Ovf, 1'b0);
    chk({tag, "_Ill"}, Ill, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  logic [4:0] ops [16];

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    n_err = 0; n_chk = 0;
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
            5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd16, 5'd10, 5'd31};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ALUOp = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("init");
    @(negedge clk); #1;
    rst = 1'b0;

    issue(5'b00011, 32'h7FFFFFFF, 32'h1);
    chk_out("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);
    issue(5'b00100, 32'h5, 32'h5);
    chk_out("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0);
    issue(5'b00000, 32'h1234, 32'h5678);
    chk_out("nop_zero", 32'h0, 1'b1, 1'b0, 1'b0);
    issue(5'b01011, 32'h80000000, 32'h24);
    chk_out("sra", 32'hF8000000, 1'b0, 1'b0, 1'b0);
    issue(5'b01001, 32'h80000000, 32'h24);
    chk_out("srl", 32'h08000000, 1'b0, 1'b0, 1'b0);
    issue(5'b00110, 32'h1, 32'hFFFFFFFF);
    chk_out("sltu", 32'h1, 1'b0, 1'b0, 1'b0);
    issue(5'b00101, 32'h1, 32'hFFFFFFFF);
    chk_out("slt", 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: result held while a second op waits
    issue(5'b00011, 32'h2, 32'h3);
    chk_out("bp_add", 32'h5, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; ALUOp = 5'b00111; A = 32'hF0; B = 32'h0F;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold_C", C, 32'h5);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    @(negedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_out("bp_next", 32'hFF, 1'b0, 1'b0, 1'b0);

    issue(5'b11111, 32'h1, 32'h2);
    chk_out("ill", 32'hFF, 1'b0, 1'b0, 1'b1);
    issue(5'b00000, 32'h0, 32'h0);
    chk_out("nop_hold", 32'hFF, 1'b0, 1'b0, 1'b0);

`ifdef ALU_MUL_EN
    issue(5'b10000, 32'hFFFFFFFD, 32'h7);
    k = 1;
    while (k <= 40) begin
      @(posedge clk); #1;
      if (out_valid) break;
      chk("mul_in_ready", in_ready, 1'b0);
      k++;
    end
    chk("mul_latency", k, 33);
    chk_out("mul", 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0);

    issue(5'b10000, 32'h12345, 32'h6789);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("mul_abort");
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("mul_abort_no_result", out_valid, 1'b0);
`else
    issue(5'b10000, 32'hFFFFFFFD, 32'h7);
    chk_out("mul_absent", 32'hFF, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic, with an asynchronous reset mid-stream
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 1500) begin
        rst = 1'b1;
        #1;
        chk_reset("mid_rst");
      end else if (rst) begin
        rst = 1'b0;
      end
      out_ready = ($urandom_range(3) != 0);
      if (!(in_valid && !m_acc_last)) begin
        in_valid = ($urandom_range(2) != 0);
        ALUOp    = ops[$urandom_range(15)];
        A        = rnd_operand();
        B        = rnd_operand();
      end
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
